mem_access_unit: RTL and testbench

//  Load/store stage directly downstream of the ALU. Takes the effective address the ALU

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/mem_lane_align.sv | 40 ++++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the load/store stage: access sizes, FSM states, bus widths,
// and the alignment helpers used by mem_access_unit.
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int BE_W      = XLEN / 8;
    localparam int REG_IDX_W = 5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } mau_state_t;

    // Size 2'b11 behaves exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return offset;
            SZ_HALF: return {offset[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data on the way out,
// lane extraction plus sign/zero extension of the read word on the way back.
module mem_lane_align
    import cpu_pkg::*;
(
    input  logic [1:0]      size,
    input  logic [1:0]      offset,
    input  logic            unsigned_ld,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [BE_W-1:0] be,
    output logic [XLEN-1:0] wdata_lane,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        be         = 4'hF;
        wdata_lane = wdata;
        shifted    = rdata;
        ld_data    = rdata;
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                shifted    = rdata >> {offset, 3'b000};
                ld_data    = {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be         = 4'b0011 << {offset[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                shifted    = rdata >> {offset[1], 4'b0000};
                ld_data    = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: one req/ack bus transaction per start, with timeout and write-back.
// Optional build macro MEM_ALIGN_CHECK_EN turns misaligned half/word accesses into faults.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_store,
    input  logic [1:0]           size,
    input  logic                 unsigned_ld,
    input  logic [XLEN-1:0]      addr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [REG_IDX_W-1:0] rd_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 wb_en,
    output logic [XLEN-1:0]      wb_data,
    output logic [REG_IDX_W-1:0] wb_idx,
    output logic                 bus_err,
    output logic                 misalign,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [BE_W-1:0]      mem_be,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_ack,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mau_state_t           state, state_next;
    logic [CNT_W-1:0]     cnt_q, cnt_next;
    logic                 store_q, uns_q, err_q, mis_q;
    logic [1:0]           size_q;
    logic [XLEN-1:0]      addr_q, wdata_q, rdata_q;
    logic [REG_IDX_W-1:0] rd_idx_q;

    logic                 accept, capture, timeout;
    logic                 mis_now;
    logic [1:0]           off_in;
    logic [BE_W-1:0]      be_lane;
    logic [XLEN-1:0]      wdata_lane, ld_data;
    logic                 wb_ok;

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_now = is_misaligned(size, addr[1:0]);
    assign off_in  = addr[1:0];
`else
    assign mis_now = 1'b0;
    assign off_in  = force_align(size, addr[1:0]);
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt_q;
        accept     = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (start) begin
                    accept     = 1'b1;
                    state_next = mis_now ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack on the last allowed cycle wins over the timeout.
                if (mem_ack) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout    = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt_q    <= '0;
            store_q  <= 1'b0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_idx_q <= '0;
        end else begin
            state <= state_next;
            cnt_q <= cnt_next;
            if (accept) begin
                store_q  <= is_store;
                uns_q    <= unsigned_ld;
                size_q   <= size;
                addr_q   <= {addr[XLEN-1:2], off_in};
                wdata_q  <= wdata;
                rd_idx_q <= rd_idx;
                err_q    <= 1'b0;
                mis_q    <= mis_now;
            end
            if (capture) rdata_q <= mem_rdata;
            if (timeout) err_q <= 1'b1;
        end
    end

    mem_lane_align u_lane (
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .unsigned_ld (uns_q),
        .wdata       (wdata_q),
        .rdata       (rdata_q),
        .be          (be_lane),
        .wdata_lane  (wdata_lane),
        .ld_data     (ld_data)
    );

    assign busy      = state != ST_IDLE;
    assign done      = state == ST_RESP;
    assign mem_req   = state == ST_REQ;
    assign mem_we    = mem_req & store_q;
    assign mem_be    = mem_req ? be_lane : '0;
    assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wdata = wdata_lane;

    assign wb_ok    = done & ~store_q & ~err_q & ~mis_q;
    assign wb_en    = wb_ok;
    assign wb_data  = wb_ok ? ld_data : '0;
    assign wb_idx   = rd_idx_q;
    assign bus_err  = done & err_q;
    assign misalign = done & mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit built with TIMEOUT_CYCLES=4.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_store, unsigned_ld;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [4:0]  rd_idx;
    logic        busy, done, wb_en, bus_err, misalign;
    logic [31:0] wb_data;
    logic [4:0]  wb_idx;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .rd_idx(rd_idx),
        .busy(busy), .done(done), .wb_en(wb_en), .wb_data(wb_data), .wb_idx(wb_idx),
        .bus_err(bus_err), .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        is_store;
        logic [1:0]  size;
        logic        uns;
        logic        misal;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          delay;
        logic        poke;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_wb_en;
        logic [31:0] e_wb;
        logic        e_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int reqc;
        bit seen_done;
        int exp_reqc;
        tick();
        is_store = v.is_store; size = v.size; unsigned_ld = v.uns;
        addr = v.addr; wdata = v.wdata; rd_idx = v.rd; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        if (v.misal) begin
            check("mis_req", mem_req, 0);
            check("mis_done", done, 1);
            check("mis_flag", misalign, 1);
            check("mis_wb_en", wb_en, 0);
            tick();
            check("mis_done_clr", done, 0);
            return;
        end
`endif
        check("req", mem_req, 1);
        check("busy", busy, 1);
        check("mem_addr", mem_addr, v.e_addr);
        check("mem_be", mem_be, v.e_be);
        check("mem_we", mem_we, v.is_store);
        check("mem_wdata", mem_wdata, v.e_wdata);
        reqc = 0;
        seen_done = 0;
        for (int k = 0; k < 12 && !seen_done; k++) begin
            mem_ack   = (k == v.delay);
            mem_rdata = (k == v.delay) ? v.rdata : 32'h5A5A_5A5A;
            if (v.poke && k == 1) start = 1'b1;
            if (mem_req) reqc++;
            tick();
            mem_ack = 1'b0;
            start   = 1'b0;
            if (done) seen_done = 1;
            else check("be_stable", mem_be, v.e_be);
        end
        exp_reqc = v.e_err ? 4 : v.delay + 1;
        check("done_seen", 32'(seen_done), 1);
        check("req_cycles", reqc, exp_reqc);
        check("wb_en", wb_en, v.e_wb_en);
        check("wb_data", wb_data, v.e_wb);
        check("wb_idx", wb_idx, v.rd);
        check("bus_err", bus_err, v.e_err);
        check("misalign", misalign, 0);
        check("req_in_resp", mem_req, 0);
        check("be_in_resp", mem_be, 0);
        check("we_in_resp", mem_we, 0);
        tick();
        check("done_pulse", done, 0);
        check("busy_clr", busy, 0);
        if (v.poke) begin
            for (int k = 0; k < 3; k++) begin
                check("no_queued_start", mem_req, 0);
                tick();
            end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // is_store size uns misal addr wdata rdata rd delay poke | be addr wdata wb_en wb err
        vecs[0]  = '{0, 2'b10, 0, 0, 32'h104, 32'h0,        32'hDEADBEEF, 5'd1,  0, 0, 4'hF,    32'h104, 32'h0,        1, 32'hDEADBEEF, 0};
        vecs[1]  = '{0, 2'b00, 0, 0, 32'h103, 32'h0,        32'h80123456, 5'd2,  0, 0, 4'b1000, 32'h100, 32'h0,        1, 32'hFFFFFF80, 0};
        vecs[2]  = '{0, 2'b00, 1, 0, 32'h103, 32'h0,        32'h80123456, 5'd3,  0, 0, 4'b1000, 32'h100, 32'h0,        1, 32'h00000080, 0};
        vecs[3]  = '{1, 2'b01, 0, 0, 32'h22,  32'h1234ABCD, 32'h0,        5'd4,  3, 0, 4'b1100, 32'h20,  32'hABCDABCD, 0, 32'h0,        0};
        vecs[4]  = '{0, 2'b10, 0, 0, 32'h40,  32'h0,        32'h11111111, 5'd5, -1, 1, 4'hF,    32'h40,  32'h0,        0, 32'h0,        1};
        vecs[5]  = '{0, 2'b10, 0, 1, 32'h101, 32'h0,        32'hCAFEF00D, 5'd6,  0, 0, 4'hF,    32'h100, 32'h0,        1, 32'hCAFEF00D, 0};
        vecs[6]  = '{1, 2'b00, 0, 0, 32'h201, 32'h000000A5, 32'h0,        5'd7,  1, 0, 4'b0010, 32'h200, 32'hA5A5A5A5, 0, 32'h0,        0};
        vecs[7]  = '{0, 2'b01, 0, 0, 32'h12,  32'h0,        32'h80017FFF, 5'd8,  0, 0, 4'b1100, 32'h10,  32'h0,        1, 32'hFFFF8001, 0};
        vecs[8]  = '{0, 2'b01, 1, 0, 32'h10,  32'h0,        32'h12348765, 5'd9,  1, 0, 4'b0011, 32'h10,  32'h0,        1, 32'h00008765, 0};
        vecs[9]  = '{0, 2'b11, 0, 0, 32'h8,   32'h0,        32'h01020304, 5'd10, 2, 0, 4'hF,    32'h8,   32'h0,        1, 32'h01020304, 0};
        vecs[10] = '{0, 2'b00, 0, 0, 32'h1,   32'h0,        32'h00007F00, 5'd11, 0, 0, 4'b0010, 32'h0,   32'h0,        1, 32'h0000007F, 0};
        vecs[11] = '{0, 2'b01, 0, 1, 32'h33,  32'h0,        32'hBEEF0000, 5'd12, 0, 0, 4'b1100, 32'h30,  32'h0,        1, 32'hFFFFBEEF, 0};

        rst = 1'b1; start = 0; is_store = 0; size = 0; unsigned_ld = 0;
        addr = 0; wdata = 0; rd_idx = 0; mem_ack = 0; mem_rdata = 0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_idx", wb_idx, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_misalign", misalign, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_be", mem_be, 0);
        check("rst_wdata", mem_wdata, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Ack while idle must not produce a completion.
        tick();
        mem_ack = 1'b1;
        tick();
        tick();
        check("idle_ack_done", done, 0);
        check("idle_ack_busy", busy, 0);
        mem_ack = 1'b0;

        // Reset in the middle of a request drops the bus immediately.
        tick();
        is_store = 0; size = 2'b10; addr = 32'h300; rd_idx = 5'd13; start = 1'b1;
        tick();
        start = 1'b0;
        check("pre_rst_req", mem_req, 1);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_busy", busy, 0);
        tick();
        check("mid_rst_done", done, 0);
        rst = 1'b0;
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
